// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
//   - Executes LDW/STW against an internal word-addressed data RAM whose
//     access takes MEM_LATENCY edges, holding the front end via O_MemBusy.
//   - Keeps the N/Z/P condition codes and resolves branch/jump redirects.
//   - Forwards scalar/vector results, opcode, dest index and bubble flags.
// Ports:
//   I_CLOCK, I_RESET_N        stage clock (negedge active), async active-low reset
//   I_LOCK, I_FetchStall,
//   I_DepStall                pipeline-running flag and upstream bubble markers
//   I_Opcode, I_DestRegIdx,
//   I_ALUOut, I_VALUOut,
//   I_DestValue               execute-stage results and STW store data
//   O_*                       registered copies for writeback, LDW read data,
//                             branch redirect (O_BranchPC/O_BranchAddrSelect)
//                             and the O_MemBusy hold for fetch/decode
module memory_stage #(
  parameter int DATA_WIDTH   = 16,
  parameter int VDATA_WIDTH  = 64,
  parameter int ADDR_BITS    = 10,
  parameter int MEM_LATENCY  = 2,
  parameter int OPCODE_WIDTH = 8,
  parameter int PC_WIDTH     = 16
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [DATA_WIDTH-1:0]   I_ALUOut,
  input  logic [VDATA_WIDTH-1:0]  I_VALUOut,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [DATA_WIDTH-1:0]   I_DestValue,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  output logic                    O_LOCK,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic [DATA_WIDTH-1:0]   O_ALUOut,
  output logic [DATA_WIDTH-1:0]   O_MemOut,
  output logic [VDATA_WIDTH-1:0]  O_VALUOut,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic [PC_WIDTH-1:0]     O_BranchPC,
  output logic                    O_BranchAddrSelect,
  output logic                    O_MemBusy
);

  // Opcode map; branch opcodes carry their n/z/p mask in bits [2:0].
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = OPCODE_WIDTH'(8'h10);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = OPCODE_WIDTH'(8'h11);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = OPCODE_WIDTH'(8'h12);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D = OPCODE_WIDTH'(8'h13);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = OPCODE_WIDTH'(8'h14);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D = OPCODE_WIDTH'(8'h15);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = OPCODE_WIDTH'(8'h20);
  localparam logic [OPCODE_WIDTH-1:0] OP_STW    = OPCODE_WIDTH'(8'h21);
  localparam logic [OPCODE_WIDTH-1:0] OP_BR     = OPCODE_WIDTH'(8'h30);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP    = OPCODE_WIDTH'(8'h40);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = OPCODE_WIDTH'(8'h41);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR   = OPCODE_WIDTH'(8'h42);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
  localparam logic [2:0] CC_Z     = 3'b010;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  // Condition code of a result, encoded {N,Z,P}.
  function automatic logic [2:0] cc_of(input logic [DATA_WIDTH-1:0] v);
    if ($signed(v) < 0)           cc_of = 3'b100;
    else if (v == '0)             cc_of = 3'b010;
    else                          cc_of = 3'b001;
  endfunction

  function automatic logic is_value_op(input logic [OPCODE_WIDTH-1:0] op);
    is_value_op = (op == OP_ADD_D) || (op == OP_ADDI_D) || (op == OP_AND_D) ||
                  (op == OP_ANDI_D) || (op == OP_MOV) || (op == OP_MOVI_D);
  endfunction

  logic [DATA_WIDTH-1:0] ram_q [0:DEPTH-1];

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [2:0]              cc_q, cc_d;
  logic [DATA_WIDTH-1:0]   lat_alu_q, lat_alu_d, lat_data_q, lat_data_d;
  logic [OPCODE_WIDTH-1:0] lat_op_q, lat_op_d;
  logic [3:0]              lat_dest_q, lat_dest_d;
  logic                    lock_q, lock_d, fstall_q, fstall_d, dstall_q, dstall_d;
  logic                    bsel_q, bsel_d, busy_q, busy_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [3:0]              dest_q, dest_d;
  logic [DATA_WIDTH-1:0]   alu_q, alu_d, memout_q, memout_d;
  logic [VDATA_WIDTH-1:0]  valu_q, valu_d;
  logic [PC_WIDTH-1:0]     bpc_q, bpc_d;

  logic                    valid_s, is_mem_s, is_branch_s, is_jump_s, we_s;
  logic [ADDR_BITS-1:0]    idx_s, lat_idx_s, widx_s;
  logic [DATA_WIDTH-1:0]   wdata_s;

  assign valid_s     = I_LOCK && !I_FetchStall && !I_DepStall;
  assign is_mem_s    = (I_Opcode == OP_LDW) || (I_Opcode == OP_STW);
  assign is_branch_s = (I_Opcode[OPCODE_WIDTH-1:3] == OP_BR[OPCODE_WIDTH-1:3]) &&
                       (I_Opcode[2:0] != 3'b000);
  assign is_jump_s   = (I_Opcode == OP_JMP) || (I_Opcode == OP_JSR) || (I_Opcode == OP_JSRR);
  // Upper address bits are dropped, so addresses wrap around the RAM.
  assign idx_s       = I_ALUOut[ADDR_BITS-1:0];
  assign lat_idx_s   = lat_alu_q[ADDR_BITS-1:0];

  // Next-state logic: IDLE capture/issue, BUSY countdown and completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cc_d       = cc_q;
    lat_alu_d  = lat_alu_q;
    lat_data_d = lat_data_q;
    lat_op_d   = lat_op_q;
    lat_dest_d = lat_dest_q;
    lock_d     = lock_q;
    op_d       = op_q;
    dest_d     = dest_q;
    alu_d      = alu_q;
    memout_d   = memout_q;
    valu_d     = valu_q;
    fstall_d   = fstall_q;
    dstall_d   = dstall_q;
    bpc_d      = bpc_q;
    bsel_d     = 1'b0;
    busy_d     = busy_q;
    we_s       = 1'b0;
    widx_s     = idx_s;
    wdata_s    = I_DestValue;
    case (state_q)
      ST_IDLE: begin
        lock_d   = I_LOCK;
        op_d     = I_Opcode;
        dest_d   = I_DestRegIdx;
        alu_d    = I_ALUOut;
        valu_d   = I_VALUOut;
        fstall_d = I_FetchStall;
        dstall_d = I_DepStall;
        if (!valid_s) begin
          cc_d = cc_q;
        end else if (is_mem_s) begin
          if (MEM_LATENCY == 1) begin
            if (I_Opcode == OP_STW) begin
              we_s = 1'b1;
            end else begin
              memout_d = ram_q[idx_s];
              cc_d     = cc_of(ram_q[idx_s]);
            end
          end else begin
            lat_alu_d  = I_ALUOut;
            lat_data_d = I_DestValue;
            lat_op_d   = I_Opcode;
            lat_dest_d = I_DestRegIdx;
            cnt_d      = CNT_INIT;
            state_d    = ST_BUSY;
            busy_d     = 1'b1;
            fstall_d   = 1'b1;   // writeback sees a bubble until completion
          end
        end else if (is_branch_s) begin
          // Uses the CC held before this edge; branches never update CC.
          if ((I_Opcode[2:0] & cc_q) != 3'b000) begin
            bpc_d  = PC_WIDTH'(I_ALUOut);
            bsel_d = 1'b1;
          end else begin
            bpc_d = bpc_q;
          end
        end else if (is_jump_s) begin
          bpc_d  = PC_WIDTH'(I_ALUOut);
          bsel_d = 1'b1;
        end else if (is_value_op(I_Opcode)) begin
          cc_d = cc_of(I_ALUOut);
        end else begin
          cc_d = cc_q;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          op_d     = lat_op_q;
          dest_d   = lat_dest_q;
          alu_d    = lat_alu_q;
          fstall_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
          if (lat_op_q == OP_STW) begin
            we_s    = 1'b1;
            widx_s  = lat_idx_s;
            wdata_s = lat_data_q;
          end else begin
            memout_d = ram_q[lat_idx_s];
            cc_d     = cc_of(ram_q[lat_idx_s]);
          end
        end else begin
          fstall_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data RAM write port; contents survive reset. Gating with reset keeps an
  // aborted access from landing.
  always_ff @(negedge I_CLOCK) begin
    if (we_s && I_RESET_N) ram_q[widx_s] <= wdata_s;
  end

  // Stage state and registered outputs.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      cc_q       <= CC_Z;
      lat_alu_q  <= '0;
      lat_data_q <= '0;
      lat_op_q   <= '0;
      lat_dest_q <= 4'd0;
      lock_q     <= 1'b0;
      op_q       <= '0;
      dest_q     <= 4'd0;
      alu_q      <= '0;
      memout_q   <= '0;
      valu_q     <= '0;
      fstall_q   <= 1'b0;
      dstall_q   <= 1'b0;
      bpc_q      <= '0;
      bsel_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cc_q       <= cc_d;
      lat_alu_q  <= lat_alu_d;
      lat_data_q <= lat_data_d;
      lat_op_q   <= lat_op_d;
      lat_dest_q <= lat_dest_d;
      lock_q     <= lock_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      alu_q      <= alu_d;
      memout_q   <= memout_d;
      valu_q     <= valu_d;
      fstall_q   <= fstall_d;
      dstall_q   <= dstall_d;
      bpc_q      <= bpc_d;
      bsel_q     <= bsel_d;
      busy_q     <= busy_d;
    end
  end

  assign O_LOCK             = lock_q;
  assign O_Opcode           = op_q;
  assign O_DestRegIdx       = dest_q;
  assign O_ALUOut           = alu_q;
  assign O_MemOut           = memout_q;
  assign O_VALUOut          = valu_q;
  assign O_FetchStall       = fstall_q;
  assign O_DepStall         = dstall_q;
  assign O_BranchPC         = bpc_q;
  assign O_BranchAddrSelect = bsel_q;
  assign O_MemBusy          = busy_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a transaction-level reference model is
// compared against every output each cycle, and hand-computed literals pin
// the model at the interesting points.
module tb_memory_stage;
  localparam int LAT = 2;
  localparam int ABITS = 10;

  localparam logic [7:0] ADD_D = 8'h10, ADDI_D = 8'h11, AND_D = 8'h12, ANDI_D = 8'h13;
  localparam logic [7:0] MOV = 8'h14, MOVI_D = 8'h15, LDW = 8'h20, STW = 8'h21;
  localparam logic [7:0] BRN = 8'h34, BRZ = 8'h32, BRP = 8'h31, BRZP = 8'h33, BRNZP = 8'h37;
  localparam logic [7:0] JMP = 8'h40, JSR = 8'h41, JSRR = 8'h42, VADD = 8'h50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lock_i = 1'b0, fs_i = 1'b0, ds_i = 1'b0;
  logic [7:0]  op_i = 8'h00;
  logic [15:0] alu_i = 16'h0, dval_i = 16'h0;
  logic [63:0] valu_i = 64'h0;
  logic [3:0]  dest_i = 4'h0;

  logic        lock_o, fs_o, ds_o, bsel_o, busy_o;
  logic [7:0]  op_o;
  logic [3:0]  dest_o;
  logic [15:0] alu_o, mem_o, bpc_o;
  logic [63:0] valu_o;

  int n_checks = 0;
  int n_fail = 0;

  memory_stage #(.DATA_WIDTH(16), .VDATA_WIDTH(64), .ADDR_BITS(ABITS), .MEM_LATENCY(LAT),
                 .OPCODE_WIDTH(8), .PC_WIDTH(16)) dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock_i), .I_Opcode(op_i),
    .I_ALUOut(alu_i), .I_VALUOut(valu_i), .I_DestRegIdx(dest_i), .I_DestValue(dval_i),
    .I_FetchStall(fs_i), .I_DepStall(ds_i),
    .O_LOCK(lock_o), .O_Opcode(op_o), .O_DestRegIdx(dest_o), .O_ALUOut(alu_o),
    .O_MemOut(mem_o), .O_VALUOut(valu_o), .O_FetchStall(fs_o), .O_DepStall(ds_o),
    .O_BranchPC(bpc_o), .O_BranchAddrSelect(bsel_o), .O_MemBusy(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mem_m [0:(1<<ABITS)-1];
  int          sign_m;      // sign of last value result: -1, 0, +1
  int          left_m;      // edges until the pending access completes
  logic [7:0]  f_op;
  logic [3:0]  f_dest;
  logic [15:0] f_addr, f_val;
  logic        f_load;
  logic        e_lock, e_fs, e_ds, e_bsel, e_busy;
  logic [7:0]  e_op;
  logic [3:0]  e_dest;
  logic [15:0] e_alu, e_mem, e_bpc;
  logic [63:0] e_valu;

  function automatic int sgn(input logic [15:0] v);
    return ($signed(v) < 0) ? -1 : ((v == 16'h0) ? 0 : 1);
  endfunction

  function automatic logic taken(input logic [2:0] m, input int s);
    return (m[2] && s < 0) || (m[1] && s == 0) || (m[0] && s > 0);
  endfunction

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem_m[a[ABITS-1:0]];
  endfunction

  initial begin
    for (int i = 0; i < (1 << ABITS); i++) mem_m[i] = 16'h0;
  end

  // Model: one transaction per edge; a memory op's result is known at
  // capture and simply shows up LAT-1 edges later.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_lock <= 1'b0; e_fs <= 1'b0; e_ds <= 1'b0; e_bsel <= 1'b0; e_busy <= 1'b0;
      e_op <= 8'h0; e_dest <= 4'h0; e_alu <= 16'h0; e_mem <= 16'h0; e_bpc <= 16'h0;
      e_valu <= 64'h0; sign_m <= 0; left_m <= 0;
    end else if (left_m != 0) begin
      left_m <= left_m - 1;
      e_bsel <= 1'b0;
      if (left_m == 1) begin
        e_op <= f_op; e_dest <= f_dest; e_alu <= f_addr; e_fs <= 1'b0; e_busy <= 1'b0;
        if (f_load) begin
          e_mem <= f_val; sign_m <= sgn(f_val);
        end else begin
          mem_m[f_addr[ABITS-1:0]] <= f_val;
        end
      end
    end else begin
      e_lock <= lock_i; e_op <= op_i; e_dest <= dest_i; e_alu <= alu_i;
      e_valu <= valu_i; e_fs <= fs_i; e_ds <= ds_i; e_bsel <= 1'b0;
      if (lock_i && !fs_i && !ds_i) begin
        if (op_i == LDW || op_i == STW) begin
          if (LAT == 1) begin
            if (op_i == STW) mem_m[alu_i[ABITS-1:0]] <= dval_i;
            else begin e_mem <= rd(alu_i); sign_m <= sgn(rd(alu_i)); end
          end else begin
            left_m <= LAT - 1; f_op <= op_i; f_dest <= dest_i; f_addr <= alu_i;
            f_load <= (op_i == LDW); f_val <= (op_i == LDW) ? rd(alu_i) : dval_i;
            e_busy <= 1'b1; e_fs <= 1'b1;
          end
        end else if (op_i inside {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37}) begin
          if (taken(op_i[2:0], sign_m)) begin e_bpc <= alu_i; e_bsel <= 1'b1; end
        end else if (op_i inside {JMP, JSR, JSRR}) begin
          e_bpc <= alu_i; e_bsel <= 1'b1;
        end else if (op_i inside {ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D}) begin
          sign_m <= sgn(alu_i);
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(posedge clk) begin
    #1;
    check("lock", lock_o, e_lock);
    check("opcode", op_o, e_op);
    check("dest", dest_o, e_dest);
    check("aluout", alu_o, e_alu);
    check("memout", mem_o, e_mem);
    check("valuout", valu_o, e_valu);
    check("fetchstall", fs_o, e_fs);
    check("depstall", ds_o, e_ds);
    check("branchpc", bpc_o, e_bpc);
    check("branchsel", bsel_o, e_bsel);
    check("membusy", busy_o, e_busy);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [7:0] op, input logic [15:0] alu, input logic [15:0] dv,
                       input logic lk, input logic fs, input logic ds, input logic [63:0] vv);
    op_i = op; alu_i = alu; dval_i = dv; lock_i = lk; fs_i = fs; ds_i = ds; valu_i = vv;
    dest_i = op[3:0];
    @(negedge clk); #1;
  endtask

  task automatic go(input logic [7:0] op, input logic [15:0] alu, input logic [15:0] dv);
    issue(op, alu, dv, 1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic wait_done;
    int n = 0;
    while (busy_o && n < 20) begin @(negedge clk); #1; n++; end
    check("busy_timeout", busy_o, 1'b0);
  endtask

  task automatic zeros_check(input string tag);
    check({tag, "_lock"}, lock_o, 1'b0);
    check({tag, "_op"}, op_o, 8'h0);
    check({tag, "_alu"}, alu_o, 16'h0);
    check({tag, "_mem"}, mem_o, 16'h0);
    check({tag, "_fs"}, fs_o, 1'b0);
    check({tag, "_bsel"}, bsel_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_bpc"}, bpc_o, 16'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 zeros_check("rst0");
    @(negedge clk); #1 rst_n = 1'b1;

    // CC=Z after reset
    go(BRZ, 16'h0100, 16'h0);
    check("brz_sel", bsel_o, 1'b1); check("brz_pc", bpc_o, 16'h0100);
    go(BRP, 16'h0200, 16'h0);
    check("brp_sel", bsel_o, 1'b0); check("brp_pc_hold", bpc_o, 16'h0100);

    // STW then LDW at latency 2
    go(STW, 16'h0010, 16'hBEEF);
    check("stw_busy", busy_o, 1'b1); check("stw_fs", fs_o, 1'b1);
    wait_done();
    go(LDW, 16'h0010, 16'h0);
    check("ldw_busy", busy_o, 1'b1);
    wait_done();
    check("ldw_mem", mem_o, 16'hBEEF); check("ldw_fs", fs_o, 1'b0);
    check("ldw_op", op_o, LDW);

    // Negative result then branches
    go(ADDI_D, 16'hFFFE, 16'h0);
    go(BRN, 16'h0040, 16'h0);
    check("brn_sel", bsel_o, 1'b1); check("brn_pc", bpc_o, 16'h0040);
    go(BRZP, 16'h0080, 16'h0);
    check("brzp_sel", bsel_o, 1'b0); check("brzp_pc", bpc_o, 16'h0040);

    // Dependency bubble: no access, CC and RAM untouched
    go(ADDI_D, 16'h0001, 16'h0);
    issue(LDW, 16'h0010, 16'h0, 1'b1, 1'b0, 1'b1, 64'h0);
    check("dep_busy", busy_o, 1'b0); check("dep_flag", ds_o, 1'b1);
    issue(STW, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 64'h0);
    check("dep_stw_busy", busy_o, 1'b0);
    go(BRP, 16'h0090, 16'h0);
    check("cc_kept_sel", bsel_o, 1'b1);
    go(LDW, 16'h0010, 16'h0); wait_done();
    check("ram_kept", mem_o, 16'hBEEF);

    // Address wrap
    go(STW, 16'h0405, 16'h1234); wait_done();
    go(LDW, 16'h0005, 16'h0); wait_done();
    check("wrap_mem", mem_o, 16'h1234);

    // Zero result, always-taken branch and jumps
    go(MOV, 16'h0000, 16'h0);
    go(BRZ, 16'h0111, 16'h0); check("mov_z_sel", bsel_o, 1'b1);
    go(BRNZP, 16'h0222, 16'h0); check("brnzp_pc", bpc_o, 16'h0222);
    go(JSRR, 16'h0300, 16'h0);
    check("jsrr_sel", bsel_o, 1'b1); check("jsrr_pc", bpc_o, 16'h0300);

    // Vector op and a locked-off bubble
    issue(VADD, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
    check("valu", valu_o, 64'h0123_4567_89AB_CDEF);
    issue(ADD_D, 16'h8000, 16'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("nolock", lock_o, 1'b0);
    go(BRZ, 16'h0333, 16'h0); check("cc_z_kept", bsel_o, 1'b1);

    // Reset in the middle of a pending STW
    go(STW, 16'h0020, 16'h1111); wait_done();
    go(STW, 16'h0020, 16'h5555);
    check("abort_busy", busy_o, 1'b1);
    #1 rst_n = 1'b0;
    #1 zeros_check("rst1");
    lock_i = 1'b0; op_i = 8'h00;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1;
    go(BRP, 16'h0444, 16'h0); check("rst_brp", bsel_o, 1'b0);
    go(BRZ, 16'h0555, 16'h0); check("rst_brz", bsel_o, 1'b1);
    go(LDW, 16'h0020, 16'h0); wait_done();
    check("abort_mem", mem_o, 16'h1111);

    issue(8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(posedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
